// File: rtl/ssd_pkg.sv
// ssd_pkg: shared segment type and hex-to-7-segment table for the ssd_mux_driver slice
package ssd_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    // active-low {a,b,c,d,e,f,g}, indexed by hex value
    localparam seg7_t SEG_LUT [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/ssd_seg7_decode.sv
// ssd_seg7_decode: combinational hex nibble to active-low 7-segment pattern
module ssd_seg7_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/ssd_mux_driver.sv
// ssd_mux_driver: time-multiplexed N-digit 7-segment driver with frame-synchronous shadow load,
// per-digit enable, decimal points and leading-zero blanking; define SSD_DIMMING_EN for PWM dimming
module ssd_mux_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 131072
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic                    load_i,
    input  logic                    blank_lz_i,
    input  logic [3:0]              bright_i,
    output logic [NUM_DIGITS-1:0]   anode,
    output seg7_t                   display,
    output logic                    dp_n,
    output logic                    frame_done_o
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PS_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         prescaler;
    logic [IW-1:0]         idx;
    logic [DW-1:0]         pend_data, shad_data;
    logic [NUM_DIGITS-1:0] pend_dp, pend_en, shad_dp, shad_en;
    logic [NUM_DIGITS-1:0] nz;
    logic [3:0]            cur_nib;
    seg7_t                 cur_seg;
    logic                  tick, boundary, lz, lit, drive;

    assign tick         = (prescaler == PS_LAST);
    assign boundary     = tick && (idx == IDX_LAST);
    assign frame_done_o = boundary;

    // slot timing: prescaler wraps every REFRESH_DIV clks, idx steps once per wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
            idx       <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // pending collects loads; shadow takes it only at the frame boundary so a frame never tears
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pend_en   <= '0;
            shad_data <= '0;
            shad_dp   <= '0;
            shad_en   <= '0;
        end else begin
            if (load_i)
                {pend_data, pend_dp, pend_en} <= {data_i, dp_i, digit_en_i};
            if (boundary)
                {shad_data, shad_dp, shad_en} <= load_i ? {data_i, dp_i, digit_en_i}
                                                        : {pend_data, pend_dp, pend_en};
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_nz
        assign nz[k] = |shad_data[4*k +: 4];
    end

    // a digit is a leading zero when it and every digit above it are zero; digit 0 always shows
    assign lz      = blank_lz_i && (idx != '0) && ((nz >> idx) == '0);
    assign lit     = shad_en[idx] && !lz;
    assign cur_nib = shad_data[4*idx +: 4];

    ssd_seg7_decode u_decode (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

`ifdef SSD_DIMMING_EN
    logic [3:0] pwm_cnt;

    // free-running dimming phase; a lit anode is gated to the first bright_i clks of every 16
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign drive = lit && (pwm_cnt < bright_i);
`else
    logic unused_bright;

    assign unused_bright = ^bright_i;
    assign drive         = lit;
`endif

    // registered pin drive; dark slots keep their timing but present all-high outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anode   <= '1;
            display <= SEG_BLANK;
            dp_n    <= 1'b1;
        end else begin
            anode   <= drive ? ~(NUM_DIGITS'(1) << idx) : '1;
            display <= lit ? cur_seg : SEG_BLANK;
            dp_n    <= lit ? ~shad_dp[idx] : 1'b1;
        end
    end

endmodule
